// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, types and helpers for the instruction-fetch front end
package fetch_pkg;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_next;
  } fetch_entry_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, power-of-two depth, async active-low reset
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [clog2(DEPTH):0]    count
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push_ok, pop_ok;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rp];
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(push_ok);
      rp    <= rp + AW'(pop_ok);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  always_ff @(posedge CLK)
    if (push_ok && !flush) mem[wp] <= wdata;
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: prefetching IF stage with redirect flush and stall handshake
// Define FETCH_BYPASS_EN for a zero-latency path from mem_rdata to ID when the queue is empty.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_gnt,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  redirect,
  input  logic [ADDR_W-1:0]     redirect_pc,
  input  logic                  id_stall,
  output logic                  inst_valid,
  output logic [DATA_W-1:0]     inst,
  output logic [ADDR_W-1:0]     inst_pc_next,
  output logic [clog2(DEPTH):0] q_count
);
  logic [ADDR_W-1:0] fpc, fpc_inc, head_pc;
  logic [DATA_W-1:0] head_instr;
  logic run, full, empty, push, q_push, q_pop;
  assign fpc_inc  = fpc + ADDR_W'(1);
  assign mem_req  = run && !full && !redirect;
  assign mem_addr = fpc;
  assign push     = mem_req && mem_gnt;
  assign q_pop    = !empty && !id_stall && !redirect;
`ifdef FETCH_BYPASS_EN
  logic byp;
  assign byp          = empty && push;
  assign q_push       = push && !(byp && !id_stall);
  assign inst_valid   = !empty || byp;
  assign inst         = !empty ? head_instr : byp ? mem_rdata : DATA_W'(NOP_INSTR);
  assign inst_pc_next = !empty ? head_pc : byp ? fpc_inc : fpc;
`else
  assign q_push       = push;
  assign inst_valid   = !empty;
  assign inst         = !empty ? head_instr : DATA_W'(NOP_INSTR);
  assign inst_pc_next = !empty ? head_pc : fpc;
`endif
  fetch_fifo #(.WIDTH(DATA_W + ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect),
    .wdata ({mem_rdata, fpc_inc}),
    .rdata ({head_instr, head_pc}),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      run <= 1'b0;
      fpc <= RESET_PC;
    end else begin
      run <= 1'b1;
      fpc <= redirect ? redirect_pc : push ? fpc_inc : fpc;
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed self-checking bench for the base (no bypass) build
module tb_fetch_prefetch_unit;
  logic        CLK = 1'b0;
  logic        RST;
  logic        mem_req, mem_gnt, redirect, id_stall, inst_valid;
  logic [15:0] mem_addr, mem_rdata, redirect_pc, inst, inst_pc_next;
  logic [2:0]  q_count;
  int total = 0, fails = 0, e;

  fetch_prefetch_unit dut (
    .CLK          (CLK),
    .RST          (RST),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rdata    (mem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .id_stall     (id_stall),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc_next (inst_pc_next),
    .q_count      (q_count)
  );

  always #5 CLK = ~CLK;
  assign mem_rdata = 16'hA000 + mem_addr;

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, 32'(mem_req), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_valid"}, 32'(inst_valid), 0);
    chk({tag, "_inst"}, 32'(inst), 32'h0800);
    chk({tag, "_pcn"}, 32'(inst_pc_next), 0);
    chk({tag, "_cnt"}, 32'(q_count), 0);
  endtask

  initial begin
    RST = 1'b0; mem_gnt = 1'b1; id_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step(); step();
    chk_reset("rst");
    RST = 1'b1;
    step();
    chk("run_req", 32'(mem_req), 1);
    chk("run_valid", 32'(inst_valid), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stream_inst", 32'(inst), 32'hA000 + 32'(i));
      chk("stream_pcn", 32'(inst_pc_next), 32'(i + 1));
    end
    id_stall = 1'b1;
    step(); step(); step();
    chk("full_cnt", 32'(q_count), 4);
    chk("full_req", 32'(mem_req), 0);
    chk("full_addr", 32'(mem_addr), 32'h0006);
    chk("full_head", 32'(inst), 32'hA002);
    id_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_inst", 32'(inst), 32'hA003 + 32'(i));
      if (i == 0) begin
        chk("drain_req", 32'(mem_req), 1);
        chk("drain_cnt", 32'(q_count), 3);
      end
    end
    chk("pre_redir_cnt", 32'(q_count), 3);
    redirect = 1'b1; redirect_pc = 16'h0040; id_stall = 1'b1;
    #1 chk("redir_req", 32'(mem_req), 0);
    step();
    redirect = 1'b0; id_stall = 1'b0;
    chk("redir_cnt", 32'(q_count), 0);
    chk("redir_valid", 32'(inst_valid), 0);
    chk("redir_addr", 32'(mem_addr), 32'h0040);
    chk("redir_pcn", 32'(inst_pc_next), 32'h0040);
    step();
    chk("redir_first", 32'(inst), 32'hA040);
    chk("redir_fvalid", 32'(inst_valid), 1);
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    chk("wrap_addr0", 32'(mem_addr), 32'hFFFE);
    step();
    chk("wrap_inst0", 32'(inst), 32'h9FFE);
    chk("wrap_pcn0", 32'(inst_pc_next), 32'hFFFF);
    chk("wrap_addr1", 32'(mem_addr), 32'hFFFF);
    step();
    chk("wrap_inst1", 32'(inst), 32'h9FFF);
    chk("wrap_pcn1", 32'(inst_pc_next), 32'h0000);
    chk("wrap_addr2", 32'(mem_addr), 32'h0000);
    step();
    chk("wrap_inst2", 32'(inst), 32'hA000);
    chk("wrap_pcn2", 32'(inst_pc_next), 32'h0001);
    redirect = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    e = 0;
    for (int i = 0; i < 16; i++) begin
      mem_gnt = (i % 2 == 0);
      step();
      if (inst_valid) begin
        chk("toggle_inst", 32'(inst), 32'hA100 + 32'(e));
        chk("toggle_pcn", 32'(inst_pc_next), 32'h0101 + 32'(e));
        e++;
      end
    end
    chk("toggle_count", 32'(e), 8);
    mem_gnt = 1'b1; id_stall = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("prerst_cnt", 32'(q_count), 4);
    RST = 1'b0;
    #1 chk_reset("async");
    @(negedge CLK);
    RST = 1'b1; id_stall = 1'b0;
    step();
    chk("post_addr", 32'(mem_addr), 0);
    chk("post_req", 32'(mem_req), 1);
    step();
    chk("post_inst", 32'(inst), 32'hA000);
    chk("post_pcn", 32'(inst_pc_next), 1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
